// File: rtl/uart_drv_pkg.sv
// Register map, STATUS bit positions, CTRL values and FSM states shared by the UART register driver.
// Pure declarations: no latency, no flow control.
package uart_drv_pkg;

    localparam logic [31:0] UART_CTRL   = 32'h00;
    localparam logic [31:0] UART_STATUS = 32'h04;
    localparam logic [31:0] UART_BAUD   = 32'h08;
    localparam logic [31:0] UART_TXDATA = 32'h0C;
    localparam logic [31:0] UART_RXDATA = 32'h10;

    localparam int STAT_TX_BUSY = 0;
    localparam int STAT_RX_OVER = 1;

    localparam logic [31:0] CTRL_TX_ONLY = 32'h1;
    localparam logic [31:0] CTRL_TX_RX   = 32'h3;

    typedef enum logic [3:0] {
        S_INIT_BAUD,
        S_INIT_GAP,
        S_INIT_CTRL,
        S_POLL,
        S_POLL_WAIT,
        S_TX_WR,
        S_RX_RD,
        S_RX_WAIT,
        S_RX_CLR
    } state_t;

endpackage

// File: rtl/uart_drv_fifo.sv
// Small pointer+count FIFO buffering TX bytes ahead of the register driver.
// Head visible combinationally; push ignored when full, pop ignored when empty.
module uart_drv_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_reg_driver.sv
// Programs BAUD/CTRL after reset, then moves TX stream bytes into TXDATA and flagged RXDATA bytes out as a stream.
// TX issue within 3 cycles of an idle poll; rx byte held until rx_ready. UART_DRV_TX_FIFO_EN adds a 4-deep TX FIFO.
module uart_reg_driver
    import uart_drv_pkg::*;
#(
    parameter logic [31:0] BAUD_DIV = 32'h1B8,
    parameter bit          RX_EN    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        we_o,
    output logic [31:0] waddr_o,
    output logic [31:0] wdata_o,
    output logic [31:0] raddr_o,
    input  logic [31:0] rdata_i,
    input  logic        tx_valid_i,
    input  logic [7:0]  tx_data_i,
    output logic        tx_ready_o,
    output logic        rx_valid_o,
    output logic [7:0]  rx_data_o,
    input  logic        rx_ready_i,
    output logic        init_done_o
);
    state_t      state;
    state_t      state_nxt;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic        tx_pop;
    logic        tx_avail;
    logic [7:0]  tx_byte;
    logic        unused_rdata;

    assign unused_rdata = ^rdata_i[31:8];

`ifdef UART_DRV_TX_FIFO_EN
    logic fifo_full;
    logic fifo_empty;

    uart_drv_fifo #(.DEPTH(4), .WIDTH(8)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_valid_i),
        .push_data (tx_data_i),
        .pop       (tx_pop),
        .pop_data  (tx_byte),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign tx_avail   = !fifo_empty;
    assign tx_ready_o = rst && !fifo_full;
`else
    assign tx_avail   = tx_valid_i;
    assign tx_byte    = tx_data_i;
    assign tx_ready_o = rst && tx_pop;
`endif

    always_ff @(posedge clk) begin
        if (!rst) state <= S_INIT_BAUD;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        we        = 1'b0;
        waddr     = '0;
        wdata     = '0;
        raddr     = UART_STATUS;
        tx_pop    = 1'b0;
        case (state)
            S_INIT_BAUD: begin
                we        = 1'b1;
                waddr     = UART_BAUD;
                wdata     = BAUD_DIV;
                state_nxt = S_INIT_GAP;
            end
            S_INIT_GAP:  state_nxt = S_INIT_CTRL;
            S_INIT_CTRL: begin
                we        = 1'b1;
                waddr     = UART_CTRL;
                wdata     = RX_EN ? CTRL_TX_RX : CTRL_TX_ONLY;
                state_nxt = S_POLL;
            end
            S_POLL:      state_nxt = S_POLL_WAIT;
            S_POLL_WAIT: begin
                // RX wins a tie so a flagged byte is drained before the UART overwrites it.
                if (RX_EN && rdata_i[STAT_RX_OVER] && !rx_valid_o)
                    state_nxt = S_RX_RD;
                else if (!rdata_i[STAT_TX_BUSY] && tx_avail)
                    state_nxt = S_TX_WR;
                else
                    state_nxt = S_POLL;
            end
            S_TX_WR: begin
                we        = 1'b1;
                waddr     = UART_TXDATA;
                wdata     = {24'h0, tx_byte};
                tx_pop    = 1'b1;
                state_nxt = S_POLL;
            end
            S_RX_RD: begin
                raddr     = UART_RXDATA;
                state_nxt = S_RX_WAIT;
            end
            S_RX_WAIT: begin
                raddr     = UART_RXDATA;
                state_nxt = S_RX_CLR;
            end
            S_RX_CLR: begin
                we        = 1'b1;
                waddr     = UART_STATUS;
                state_nxt = S_POLL;
            end
            default:     state_nxt = S_INIT_BAUD;
        endcase
    end

    // Bus outputs are quiet while reset is held, even before the first clock edge.
    assign we_o    = rst && we;
    assign waddr_o = rst ? waddr : '0;
    assign wdata_o = rst ? wdata : '0;
    assign raddr_o = rst ? raddr : UART_STATUS;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_valid_o  <= 1'b0;
            rx_data_o   <= '0;
            init_done_o <= 1'b0;
        end else begin
            if (state == S_INIT_CTRL) init_done_o <= 1'b1;
            if (state == S_RX_WAIT) begin
                rx_data_o  <= rdata_i[7:0];
                rx_valid_o <= 1'b1;
            end else if (rx_valid_o && rx_ready_i) begin
                rx_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_reg_driver.sv
// Directed bench for uart_reg_driver with a registered-read UART register model and a write log.
module tb_uart_reg_driver;

    logic        clk;
    logic        rst;
    logic        we_o;
    logic [31:0] waddr_o;
    logic [31:0] wdata_o;
    logic [31:0] raddr_o;
    logic [31:0] rdata_i;
    logic        tx_valid_i;
    logic [7:0]  tx_data_i;
    logic        tx_ready_o;
    logic        rx_valid_o;
    logic [7:0]  rx_data_o;
    logic        rx_ready_i;
    logic        init_done_o;

    logic [31:0] status;
    logic [7:0]  rxdata;

    int checks   = 0;
    int failures = 0;

    logic [31:0] wa_q [$];
    logic [31:0] wd_q [$];
    int          wc_q [$];
    logic        wi_q [$];
    int          cyc   = 0;
    int          b2b   = 0;
    int          txr   = 0;
    int          rd10  = 0;
    logic        prev_we = 1'b0;

    uart_reg_driver dut (
        .clk         (clk),
        .rst         (rst),
        .we_o        (we_o),
        .waddr_o     (waddr_o),
        .wdata_o     (wdata_o),
        .raddr_o     (raddr_o),
        .rdata_i     (rdata_i),
        .tx_valid_i  (tx_valid_i),
        .tx_data_i   (tx_data_i),
        .tx_ready_o  (tx_ready_o),
        .rx_valid_o  (rx_valid_o),
        .rx_data_o   (rx_data_o),
        .rx_ready_i  (rx_ready_i),
        .init_done_o (init_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // UART read port: data registered from the address of the previous cycle.
    always @(posedge clk) begin
        if (raddr_o == 32'h04)      rdata_i <= status;
        else if (raddr_o == 32'h10) rdata_i <= {24'h0, rxdata};
        else                        rdata_i <= 32'h0;
    end

    always @(negedge clk) begin
        if (we_o) begin
            wa_q.push_back(waddr_o);
            wd_q.push_back(wdata_o);
            wc_q.push_back(cyc);
            wi_q.push_back(init_done_o);
            if (prev_we) b2b++;
        end
        prev_we = we_o;
        if (tx_ready_o) txr++;
        if (raddr_o == 32'h10) rd10++;
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_writes(input int base, input int n, input int budget, input string tag);
        for (int i = 0; i < budget && (wa_q.size() - base) < n; i++) tick();
        chk(tag, 32'(wa_q.size() - base >= n), 32'd1);
    endtask

    task automatic wait_rx(input int budget, input string tag);
        for (int i = 0; i < budget && !rx_valid_o; i++) tick();
        chk(tag, {31'h0, rx_valid_o}, 32'd1);
    endtask

    task automatic check_init(input int base, input string tag);
        chk({tag, "_nwr"}, 32'(wa_q.size() - base), 32'd2);
        if (wa_q.size() - base >= 2) begin
            chk({tag, "_baud_addr"}, wa_q[base], 32'h08);
            chk({tag, "_baud_data"}, wd_q[base], 32'h1B8);
            chk({tag, "_ctrl_addr"}, wa_q[base+1], 32'h00);
            chk({tag, "_ctrl_data"}, wd_q[base+1], 32'h3);
            chk({tag, "_gap"}, 32'(wc_q[base+1] - wc_q[base]), 32'd2);
            chk({tag, "_done_at_ctrl"}, {31'h0, wi_q[base+1]}, 32'd0);
        end
        chk({tag, "_done"}, {31'h0, init_done_o}, 32'd1);
    endtask

    initial begin
        int base;
        int rbase;
        int tbase;
        int c_start;

        rst        = 1'b0;
        status     = 32'h0;
        rxdata     = 8'h0;
        tx_valid_i = 1'b0;
        tx_data_i  = 8'h0;
        rx_ready_i = 1'b0;

        repeat (3) tick();
        @(negedge clk);
        chk("rst_we",      {31'h0, we_o},        32'd0);
        chk("rst_waddr",   waddr_o,              32'h0);
        chk("rst_wdata",   wdata_o,              32'h0);
        chk("rst_raddr",   raddr_o,              32'h04);
        chk("rst_txready", {31'h0, tx_ready_o},  32'd0);
        chk("rst_rxvalid", {31'h0, rx_valid_o},  32'd0);
        chk("rst_rxdata",  {24'h0, rx_data_o},   32'h0);
        chk("rst_done",    {31'h0, init_done_o}, 32'd0);

        // Release reset: BAUD write, idle cycle, CTRL write, then polling.
        tick();
        base = wa_q.size();
        rst  = 1'b1;
        repeat (3) tick();
        check_init(base, "init");

`ifndef UART_DRV_TX_FIFO_EN
        // Single TX byte with the UART idle.
        base       = wa_q.size();
        tbase      = txr;
        c_start    = cyc;
        tx_valid_i = 1'b1;
        tx_data_i  = 8'hA5;
        wait_writes(base, 1, 10, "tx_issue");
        tx_valid_i = 1'b0;
        if (wa_q.size() > base) begin
            chk("tx_addr", wa_q[base], 32'h0C);
            chk("tx_data", wd_q[base], 32'hA5);
            chk("tx_latency_le3", 32'(wc_q[base] - c_start <= 2), 32'd1);
        end
        repeat (4) tick();
        chk("tx_ready_once", 32'(txr - tbase), 32'd1);

        // UART busy: polls only, no TXDATA write until busy drops.
        status = 32'h1;
        repeat (2) tick();
        base       = wa_q.size();
        tbase      = txr;
        tx_valid_i = 1'b1;
        tx_data_i  = 8'h5A;
        repeat (50) tick();
        chk("busy_no_write", 32'(wa_q.size() - base), 32'd0);
        chk("busy_no_ready", 32'(txr - tbase), 32'd0);
        status = 32'h0;
        wait_writes(base, 1, 10, "busy_release");
        tx_valid_i = 1'b0;
        if (wa_q.size() > base) begin
            chk("busy_tx_addr", wa_q[base], 32'h0C);
            chk("busy_tx_data", wd_q[base], 32'h5A);
        end
        repeat (4) tick();
`endif

        // RX byte: read RXDATA, present it, clear STATUS bit1.
        base   = wa_q.size();
        rbase  = rd10;
        rxdata = 8'h3C;
        status = 32'h2;
        wait_rx(12, "rx_valid");
        status = 32'h0;
        chk("rx_data", {24'h0, rx_data_o}, 32'h3C);
        repeat (2) tick();
        // A second byte is flagged while the first is still held.
        status = 32'h2;
        rxdata = 8'h77;
        repeat (20) tick();
        chk("rx_hold_valid", {31'h0, rx_valid_o}, 32'd1);
        chk("rx_hold_data",  {24'h0, rx_data_o},  32'h3C);
        chk("rx_single_read", 32'(rd10 - rbase), 32'd2);
        chk("rx_nwr", 32'(wa_q.size() - base), 32'd1);
        if (wa_q.size() > base) begin
            chk("rx_clr_addr", wa_q[base], 32'h04);
            chk("rx_clr_data", wd_q[base], 32'h0);
        end
        rx_ready_i = 1'b1;
        tick();
        rx_ready_i = 1'b0;
        chk("rx_consumed", {31'h0, rx_valid_o}, 32'd0);
        wait_rx(12, "rx2_valid");
        status = 32'h0;
        chk("rx2_data", {24'h0, rx_data_o}, 32'h77);
        rx_ready_i = 1'b1;
        tick();
        rx_ready_i = 1'b0;
        repeat (4) tick();

`ifndef UART_DRV_TX_FIFO_EN
        // RX and TX become eligible in the same poll: RX goes first.
        status     = 32'h1;
        repeat (2) tick();
        base       = wa_q.size();
        tx_valid_i = 1'b1;
        tx_data_i  = 8'h22;
        rxdata     = 8'h11;
        status     = 32'h2;
        wait_writes(base, 2, 20, "prio_writes");
        tx_valid_i = 1'b0;
        if (wa_q.size() - base >= 2) begin
            chk("prio_first_rx",  wa_q[base],   32'h04);
            chk("prio_second_tx", wa_q[base+1], 32'h0C);
            chk("prio_tx_data",   wd_q[base+1], 32'h22);
        end
        chk("prio_rx_data", {24'h0, rx_data_o}, 32'h11);
        status     = 32'h0;
        rx_ready_i = 1'b1;
        tick();
        rx_ready_i = 1'b0;
        repeat (4) tick();
`else
        // FIFO: five offers with the UART busy, four accepted, drained in order.
        status = 32'h1;
        repeat (2) tick();
        base = wa_q.size();
        for (int i = 0; i < 5; i++) begin
            tx_valid_i = 1'b1;
            tx_data_i  = 8'(i + 1);
            @(negedge clk);
            chk($sformatf("fifo_ready_%0d", i), {31'h0, tx_ready_o}, (i < 4) ? 32'd1 : 32'd0);
            tick();
        end
        tx_valid_i = 1'b0;
        chk("fifo_busy_no_write", 32'(wa_q.size() - base), 32'd0);
        status = 32'h0;
        wait_writes(base, 4, 40, "fifo_drain");
        if (wa_q.size() - base >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("fifo_addr_%0d", i), wa_q[base+i], 32'h0C);
                chk($sformatf("fifo_data_%0d", i), wd_q[base+i], 32'(i + 1));
            end
        end
        repeat (4) tick();
`endif

        // Reset with a byte pending: byte dropped, UART reprogrammed.
        rxdata = 8'h99;
        status = 32'h2;
        wait_rx(12, "mid_rx_valid");
        status = 32'h0;
        rst    = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        chk("mid_rst_rxvalid", {31'h0, rx_valid_o},  32'd0);
        chk("mid_rst_done",    {31'h0, init_done_o}, 32'd0);
        chk("mid_rst_we",      {31'h0, we_o},        32'd0);
        tick();
        base = wa_q.size();
        rst  = 1'b1;
        repeat (3) tick();
        check_init(base, "reinit");

        chk("no_back_to_back_we", 32'(b2b), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
